aes256_seq_ctrl: RTL and testbench



---
 rtl/aes256_ctrl_pkg.sv | 31 +++
 rtl/aes256_seq_timeout.sv | 37 +++
 rtl/aes256_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_aes256_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes256_ctrl_pkg.sv
// AES256 sequencer shared definitions: FSM states, register word map
// and CTRL/STATUS bit positions.
package aes256_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_KEY_LOAD  = 3'd1,
      ST_KEY_WAIT  = 3'd2,
      ST_ENC_ISSUE = 3'd3,
      ST_ENC_WAIT  = 3'd4
   } state_e;

   localparam logic [4:0] ADDR_KEY0   = 5'd0;
   localparam logic [4:0] ADDR_DIN0   = 5'd8;
   localparam logic [4:0] ADDR_CTRL   = 5'd12;
   localparam logic [4:0] ADDR_STATUS = 5'd13;
   localparam logic [4:0] ADDR_DOUT0  = 5'd16;
   localparam logic [4:0] ADDR_DOUT3  = 5'd19;

   localparam int CTRL_START    = 0;
   localparam int CTRL_KEY_LOAD = 1;
   localparam int CTRL_CLR_DONE = 2;
   localparam int CTRL_CLR_ERR  = 3;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_KEY_VALID = 2;
   localparam int STAT_ERROR     = 3;
   localparam int STAT_TIMEOUT   = 4;

endpackage

// File: rtl/aes256_seq_timeout.sv
// Wait-state watchdog: counts enabled cycles since the last clear and
// flags expiry on the LIMIT-th enabled cycle.
module aes256_seq_timeout
   import aes256_ctrl_pkg::*;
#(
   parameter int LIMIT = 1024,
   parameter int CNT_W = 11
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/aes256_seq_ctrl.sv
// AES256 register sequencer: key/plaintext/result words and core handshake.
// Optional AES_SEQ_AUTOSTART_EN: a DIN3 write with a valid key launches encryption.
module aes256_seq_ctrl
   import aes256_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic         ACLK,
   input  logic         ARESETN,
   input  logic         reg_wr_en,
   input  logic [4:0]   reg_wr_addr,
   input  logic [31:0]  reg_wr_data,
   input  logic [4:0]   reg_rd_addr,
   output logic [31:0]  reg_rd_data,
   output logic [255:0] core_key,
   output logic         core_key_load,
   input  logic         core_key_ready,
   output logic [127:0] core_din,
   output logic         core_start,
   input  logic         core_done,
   input  logic [127:0] core_dout,
   output logic         busy
);

   state_e           state_q, state_d;
   logic [7:0][31:0] key_q, key_d;
   logic [3:0][31:0] din_q, din_d;
   logic [3:0][31:0] dout_q, dout_d;
   logic             done_q, done_d;
   logic             kv_q, kv_d;
   logic             err_q, err_d;
   logic             tmo_q, tmo_d;
   logic [31:0]      rd_q, rd_d;
   logic [31:0]      status;
   logic [3:0]       ctrl;
   logic             idle, wr_key, wr_din, wr_ctrl, blocked;
   logic             auto_go, expired;

   assign idle    = (state_q == ST_IDLE);
   assign wr_key  = reg_wr_en && (reg_wr_addr < ADDR_DIN0);
   assign wr_din  = reg_wr_en && (reg_wr_addr >= ADDR_DIN0)
                    && (reg_wr_addr < ADDR_CTRL);
   assign wr_ctrl = reg_wr_en && (reg_wr_addr == ADDR_CTRL);
   assign blocked = !idle && (wr_key || wr_din || wr_ctrl);
   assign ctrl    = (wr_ctrl && idle) ? reg_wr_data[3:0] : 4'd0;

`ifdef AES_SEQ_AUTOSTART_EN
   assign auto_go = idle && wr_din && (reg_wr_addr[1:0] == 2'd3) && kv_q;
`else
   assign auto_go = 1'b0;
`endif

   assign busy          = !idle;
   assign core_key_load = (state_q == ST_KEY_LOAD);
   assign core_start    = (state_q == ST_ENC_ISSUE);
   assign core_key      = key_q;
   assign core_din      = din_q;
   assign reg_rd_data   = rd_q;

   aes256_seq_timeout #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk_i     (ACLK),
      .rst_ni    (ARESETN),
      .clr_i     (core_key_load || core_start),
      .en_i      ((state_q == ST_KEY_WAIT) || (state_q == ST_ENC_WAIT)),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      din_d   = din_q;
      dout_d  = dout_q;
      done_d  = done_q;
      kv_d    = kv_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      if (ctrl[CTRL_CLR_DONE]) done_d = 1'b0;
      if (ctrl[CTRL_CLR_ERR]) begin
         err_d = 1'b0;
         tmo_d = 1'b0;
      end
      if (blocked) err_d = 1'b1;
      if (idle && wr_key) begin
         key_d[reg_wr_addr[2:0]] = reg_wr_data;
         kv_d = 1'b0;
      end
      if (idle && wr_din) din_d[reg_wr_addr[1:0]] = reg_wr_data;
      unique case (state_q)
         ST_IDLE: begin
            if (ctrl[CTRL_KEY_LOAD]) begin
               kv_d    = 1'b0;
               state_d = ST_KEY_LOAD;
               if (ctrl[CTRL_START]) err_d = 1'b1;
            end else if (ctrl[CTRL_START] || auto_go) begin
               if (kv_q) state_d = ST_ENC_ISSUE;
               else      err_d   = 1'b1;
            end
         end
         ST_KEY_LOAD: state_d = ST_KEY_WAIT;
         ST_KEY_WAIT: begin
            if (core_key_ready) begin
               kv_d    = 1'b1;
               state_d = ST_IDLE;
            end else if (expired) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ENC_ISSUE: begin
            done_d  = 1'b0;
            state_d = ST_ENC_WAIT;
         end
         ST_ENC_WAIT: begin
            if (core_done) begin
               dout_d  = core_dout;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (expired) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      status                 = '0;
      status[STAT_BUSY]      = !idle;
      status[STAT_DONE]      = done_q;
      status[STAT_KEY_VALID] = kv_q;
      status[STAT_ERROR]     = err_q;
      status[STAT_TIMEOUT]   = tmo_q;
      rd_d = '0;
      if (reg_rd_addr < ADDR_DIN0) begin
         rd_d = key_q[reg_rd_addr[2:0]];
      end else if (reg_rd_addr < ADDR_CTRL) begin
         rd_d = din_q[reg_rd_addr[1:0]];
      end else if (reg_rd_addr == ADDR_STATUS) begin
         rd_d = status;
      end else if ((reg_rd_addr >= ADDR_DOUT0) && (reg_rd_addr <= ADDR_DOUT3)) begin
         rd_d = dout_q[reg_rd_addr[1:0]];
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         din_q   <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         kv_q    <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         kv_q    <= kv_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         rd_q    <= rd_d;
      end
   end

endmodule

// File: tb/tb_aes256_seq_ctrl.sv
// Self-checking bench for aes256_seq_ctrl: directed steps plus a randomized
// phase checked against a word-map reference model and a simple core model.
module tb_aes256_seq_ctrl;
   import aes256_ctrl_pkg::*;

   logic         ACLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic         reg_wr_en = 1'b0;
   logic [4:0]   reg_wr_addr = '0;
   logic [31:0]  reg_wr_data = '0;
   logic [4:0]   reg_rd_addr = '0;
   logic [31:0]  reg_rd_data;
   logic [255:0] core_key;
   logic         core_key_load;
   logic         core_key_ready = 1'b0;
   logic [127:0] core_din;
   logic         core_start;
   logic         core_done = 1'b0;
   logic [127:0] core_dout = '0;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int kl_cnt = 0, st_cnt = 0, key_tmr = 0, enc_tmr = 0;
   bit core_resp = 1'b1;
   logic [127:0] ct_next = '0;
   logic [127:0] seen_din = '0;
   logic [255:0] seen_key = '0;

   logic [31:0] ref_key [8];
   logic [31:0] ref_din [4];
   logic [31:0] ref_dout [4];
   bit ref_kv, ref_done, ref_err, ref_tmo;

   aes256_seq_ctrl dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .reg_wr_en      (reg_wr_en),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .reg_rd_addr    (reg_rd_addr),
      .reg_rd_data    (reg_rd_data),
      .core_key       (core_key),
      .core_key_load  (core_key_load),
      .core_key_ready (core_key_ready),
      .core_din       (core_din),
      .core_start     (core_start),
      .core_done      (core_done),
      .core_dout      (core_dout),
      .busy           (busy)
   );

   always #5 ACLK = ~ACLK;

   // Core stand-in: key ready 20 cycles after load, result 14 cycles after start.
   always @(posedge ACLK) begin
      core_done <= 1'b0;
      if (core_key_load) begin
         kl_cnt++;
         key_tmr = 20;
         core_key_ready <= 1'b0;
      end else if (key_tmr > 0) begin
         key_tmr--;
         if (key_tmr == 0) core_key_ready <= 1'b1;
      end
      if (core_start) begin
         st_cnt++;
         seen_din = core_din;
         seen_key = core_key;
         enc_tmr = core_resp ? 14 : 0;
      end else if (enc_tmr > 0) begin
         enc_tmr--;
         if (enc_tmr == 0) begin
            core_done <= 1'b1;
            core_dout <= ct_next;
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      reg_wr_en   = 1'b1;
      reg_wr_addr = a;
      reg_wr_data = d;
      step(1);
      reg_wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      reg_rd_addr = a;
      step(1);
      d = reg_rd_data;
   endtask

   task automatic wait_idle(input int budget, input string tag, output int n);
      n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      chk(tag, busy, 1'b0);
   endtask

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      logic [31:0] s;
      s = {27'd0, ref_tmo, ref_err, ref_kv, ref_done, 1'b0};
      if (a < 5'd8) return ref_key[a[2:0]];
      if (a < 5'd12) return ref_din[a[1:0]];
      if (a == 5'd13) return s;
      if (a >= 5'd16 && a < 5'd20) return ref_dout[a[1:0]];
      return 32'd0;
   endfunction

   function automatic logic [255:0] key_cat();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = ref_key[i];
      return k;
   endfunction

   function automatic logic [127:0] din_cat();
      logic [127:0] k;
      for (int i = 0; i < 4; i++) k[32*i +: 32] = ref_din[i];
      return k;
   endfunction

   task automatic ref_clear();
      for (int i = 0; i < 8; i++) ref_key[i] = '0;
      for (int i = 0; i < 4; i++) begin
         ref_din[i]  = '0;
         ref_dout[i] = '0;
      end
      ref_kv = 0; ref_done = 0; ref_err = 0; ref_tmo = 0;
   endtask

   task automatic chk_rd(input string tag, input logic [4:0] a);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, ref_read(a));
   endtask

   // Called right after the write that should launch encryption.
   task automatic enc_after_trigger(input int s0);
      int n;
      chk("start_pulse", core_start, 1'b1);
      chk("core_din", core_din, din_cat());
      step(1);
      chk("start_single", core_start, 1'b0);
      n = 0;
      while (!core_done && n < 60) begin
         step(1);
         n++;
      end
      chk("done_seen", core_done, 1'b1);
      chk("busy_at_done", busy, 1'b1);
      step(1);
      chk("idle_after_done", busy, 1'b0);
      chk("start_count", st_cnt - s0, 1);
      chk("enc_key", seen_key, key_cat());
      ref_done = 1'b1;
      for (int i = 0; i < 4; i++) ref_dout[i] = ct_next[32*i +: 32];
   endtask

   initial begin
      logic [31:0] d;
      int n, s0, k0, idx, op;
      ref_clear();

      step(3);
      chk("rst_busy", busy, 1'b0);
      chk("rst_keyload", core_key_load, 1'b0);
      chk("rst_start", core_start, 1'b0);
      chk("rst_rdata", reg_rd_data, 32'd0);
      ARESETN = 1'b1;
      step(1);
      rd(ADDR_STATUS, d);
      chk("rst_status", d, 32'h0);

      for (int i = 0; i < 8; i++) begin
         ref_key[i] = 32'h00010203 + i * 32'h04040404;
         wr(5'(i), ref_key[i]);
      end
      k0 = kl_cnt;
      wr(ADDR_CTRL, 32'h2);
      chk("keyload_pulse", core_key_load, 1'b1);
      wait_idle(60, "keyload_idle", n);
      ref_kv = 1'b1;
      chk("keyload_count", kl_cnt - k0, 1);
      chk("core_key", core_key, key_cat());
      rd(ADDR_STATUS, d);
      chk("status_key", d, 32'h4);

      ref_din[0] = 32'h00112233; ref_din[1] = 32'h44556677;
      ref_din[2] = 32'h8899aabb; ref_din[3] = 32'hccddeeff;
      ct_next = 128'h8ea2b7ca516745bfeafc49904b496089;
      for (int i = 0; i < 3; i++) wr(5'(8 + i), ref_din[i]);
      s0 = st_cnt;
      wr(5'd11, ref_din[3]);
`ifdef AES_SEQ_AUTOSTART_EN
      enc_after_trigger(s0);
`else
      step(3);
      chk("no_autostart", st_cnt - s0, 0);
      s0 = st_cnt;
      wr(ADDR_CTRL, 32'h1);
      enc_after_trigger(s0);
`endif
      rd(ADDR_DOUT0, d);
      chk("dout0", d, 32'h4b496089);
      rd(ADDR_DOUT3, d);
      chk("dout3", d, 32'h8ea2b7ca);
      rd(ADDR_STATUS, d);
      chk("status_done", d, 32'h6);

      wr(ADDR_KEY0, ref_key[0]);
      ref_kv = 1'b0;
      wr(ADDR_CTRL, 32'h4);
      ref_done = 1'b0;
      s0 = st_cnt;
      wr(ADDR_CTRL, 32'h1);
      step(3);
      chk("nokey_no_start", st_cnt - s0, 0);
      rd(ADDR_STATUS, d);
      chk("status_nokey_err", d, 32'h8);
      wr(ADDR_CTRL, 32'h8);
      rd(ADDR_STATUS, d);
      chk("status_clr_err", d, 32'h0);

      wr(ADDR_CTRL, 32'h2);
      wait_idle(60, "reload_idle", n);
      ref_kv = 1'b1;
      core_resp = 1'b0;
      wr(ADDR_CTRL, 32'h1);
      wait_idle(1100, "timeout_idle", n);
      chk("timeout_cycles", (n >= 1024 && n <= 1026), 1'b1);
      rd(ADDR_STATUS, d);
      chk("status_timeout", d, 32'h1c);
      rd(ADDR_DOUT0, d);
      chk("timeout_dout0", d, 32'h4b496089);
      core_resp = 1'b1;
      wr(ADDR_CTRL, 32'h8);

      ct_next = {$urandom, $urandom, $urandom, $urandom};
      s0 = st_cnt;
      wr(ADDR_CTRL, 32'h1);
      step(3);
      wr(ADDR_KEY0, 32'hdeadbeef);
      wait_idle(40, "busywr_idle", n);
      chk("busywr_starts", st_cnt - s0, 1);
      rd(ADDR_KEY0, d);
      chk("busywr_key0", d, 32'h00010203);
      rd(ADDR_STATUS, d);
      chk("busywr_status", d, 32'he);
      rd(ADDR_DOUT0, d);
      chk("busywr_dout0", d, ct_next[31:0]);
      for (int i = 0; i < 4; i++) ref_dout[i] = ct_next[32*i +: 32];

      k0 = kl_cnt;
      s0 = st_cnt;
      wr(ADDR_CTRL, 32'h3);
      wait_idle(60, "both_idle", n);
      chk("both_keyload", kl_cnt - k0, 1);
      chk("both_no_start", st_cnt - s0, 0);
      rd(ADDR_STATUS, d);
      chk("both_status", d, 32'he);
      wr(ADDR_CTRL, 32'hc);
      rd(ADDR_STATUS, d);
      chk("both_clr", d, 32'h4);
      ref_kv = 1; ref_done = 0; ref_err = 0; ref_tmo = 0;

      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               idx = $urandom_range(0, 7);
               d = $urandom;
               wr(5'(idx), d);
               ref_key[idx] = d;
               ref_kv = 1'b0;
            end
            1: begin
               idx = $urandom_range(0, 3);
               d = $urandom;
               ct_next = {$urandom, $urandom, $urandom, $urandom};
               s0 = st_cnt;
               wr(5'(8 + idx), d);
               ref_din[idx] = d;
`ifdef AES_SEQ_AUTOSTART_EN
               if (idx == 3 && ref_kv) enc_after_trigger(s0);
               else chk("din_no_start", core_start, 1'b0);
`else
               chk("din_no_start", core_start, 1'b0);
`endif
            end
            2: chk_rd("rand_read", 5'($urandom_range(0, 31)));
            3: begin
               ct_next = {$urandom, $urandom, $urandom, $urandom};
               s0 = st_cnt;
               wr(ADDR_CTRL, 32'h1);
               if (ref_kv) begin
                  enc_after_trigger(s0);
               end else begin
                  ref_err = 1'b1;
                  step(2);
                  chk("rand_no_start", st_cnt - s0, 0);
               end
            end
            4: begin
               k0 = kl_cnt;
               wr(ADDR_CTRL, 32'h2);
               wait_idle(60, "rand_key_idle", n);
               ref_kv = 1'b1;
               chk("rand_keyload", kl_cnt - k0, 1);
            end
            default: begin
               d = 32'($urandom_range(0, 3)) << 2;
               wr(ADDR_CTRL, d);
               if (d[2]) ref_done = 1'b0;
               if (d[3]) begin
                  ref_err = 1'b0;
                  ref_tmo = 1'b0;
               end
            end
         endcase
      end
      chk_rd("final_status", ADDR_STATUS);
      for (int i = 0; i < 8; i++) chk_rd("final_key", 5'(i));
      for (int i = 0; i < 4; i++) chk_rd("final_din", 5'(8 + i));
      for (int i = 0; i < 4; i++) chk_rd("final_dout", 5'(16 + i));

      wr(ADDR_CTRL, 32'h2);
      step(5);
      chk("pre_rst_busy", busy, 1'b1);
      k0 = kl_cnt;
      s0 = st_cnt;
      ARESETN = 1'b0;
      #1;
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_kl", core_key_load, 1'b0);
      step(1);
      ARESETN = 1'b1;
      ref_clear();
      step(1);
      chk_rd("rst_mid_status", ADDR_STATUS);
      chk_rd("rst_mid_key0", ADDR_KEY0);
      chk_rd("rst_mid_din0", ADDR_DIN0);
      chk_rd("rst_mid_dout0", ADDR_DOUT0);
      step(40);
      chk("rst_no_keyload", kl_cnt - k0, 0);
      chk("rst_no_start", st_cnt - s0, 0);
      chk("rst_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
